lp_fp_mult_sched: RTL and testbench



---
 rtl/lp_fp_mult_sched_pkg.sv | 31 +++
 rtl/rr_arb_onehot.sv | 31 +++
 rtl/lp_fp_mult_sched.sv | 176 +++++++++++++++++
 tb/tb_lp_fp_mult_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_fp_mult_sched_pkg.sv
// Shared sizing helpers and constants for the FP multiplier scheduler.
package lp_fp_mult_sched_pkg;

  // Rounding-mode and status widths of the multiplier interface.
  localparam int rnd_w    = 3;
  localparam int status_w = 8;

  // Operand width for the default single-precision configuration.
  localparam int default_op_w = 23 + 8 + 1;

  // Requester index width; at least one bit even for two requesters.
  function automatic int calc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sequence field width: whatever the launch id leaves above the index.
  function automatic int calc_seq_w(input int id_w, input int n);
    return id_w - calc_idx_w(n);
  endfunction

  // Outstanding counter width; must be able to hold max_out itself.
  function automatic int calc_cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  // Operand width: sign + exponent + significand.
  function automatic int calc_op_w(input int sig_w, input int exp_w);
    return sig_w + exp_w + 1;
  endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// Round-robin arbiter: first requester at or after ptr wins.
// Reusable by any scheduler that shares one resource among N clients.
module rr_arb_onehot #(
  parameter int N  = 4,
  parameter int IW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan ptr, ptr+1, ... (mod N) and keep the first asserted request.
  always_comb begin : pick
    int cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/lp_fp_mult_sched.sv
// Shares one pipelined FP multiplier between num_req requesters:
// round-robin launch arbitration, result steering by launch id,
// per-requester outstanding limits and sticky arrival error detection.
module lp_fp_mult_sched
  import lp_fp_mult_sched_pkg::*;
#(
  parameter int num_req   = 4,
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int id_width  = 8,
  parameter int max_out   = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [num_req-1:0]                             req,
  input  logic [num_req*(sig_width+exp_width+1)-1:0]     req_a,
  input  logic [num_req*(sig_width+exp_width+1)-1:0]     req_b,
  input  logic [num_req*3-1:0]                           req_rnd,
  output logic [num_req-1:0]                             gnt,
  output logic [num_req-1:0]                             rsp_valid,
  input  logic [num_req-1:0]                             rsp_ready,
  output logic [sig_width+exp_width:0]                   rsp_z,
  output logic [7:0]                                     rsp_status,
  output logic                                           mult_launch,
  output logic [id_width-1:0]                            mult_launch_id,
  output logic [sig_width+exp_width:0]                   mult_a,
  output logic [sig_width+exp_width:0]                   mult_b,
  output logic [2:0]                                     mult_rnd,
  input  logic                                           mult_pipe_full,
  input  logic                                           mult_arrive,
  input  logic [id_width-1:0]                            mult_arrive_id,
  input  logic [sig_width+exp_width:0]                   mult_z,
  input  logic [7:0]                                     mult_status,
  output logic                                           mult_accept_n,
  output logic                                           busy,
  output logic                                           err
);

  localparam int idx_w = calc_idx_w(num_req);
  localparam int seq_w = calc_seq_w(id_width, num_req);
  localparam int cnt_w = calc_cnt_w(max_out);
  localparam int op_w  = calc_op_w(sig_width, exp_width);

  logic [idx_w-1:0]  rr_ptr;
  logic [idx_w-1:0]  gnt_idx;
  logic [idx_w-1:0]  dst;
  logic [seq_w-1:0]  seq;
  logic [seq_w-1:0]  exp_seq;
  logic [seq_w-1:0]  arr_seq;
  logic [cnt_w-1:0]  out_cnt [num_req];
  logic [num_req-1:0] elig;
  logic [num_req-1:0] nonzero;
  logic [num_req-1:0] cand_req;
  logic [num_req-1:0] inc_vec;
  logic [num_req-1:0] dec_vec;
  logic              launch;
  logic              dst_ok;
  logic              dst_ready;
  logic              dst_cnt_zero;
  logic              consume;
  logic              arr_err;

  // Eligibility: pending request with headroom under the outstanding limit.
  always_comb begin
    elig    = '0;
    nonzero = '0;
    for (int i = 0; i < num_req; i++) begin
      elig[i]    = req[i] && (out_cnt[i] != cnt_w'(max_out));
      nonzero[i] = (out_cnt[i] != '0);
    end
  end

  // No launches while the multiplier is full or while held in reset.
  assign cand_req = elig & {num_req{rst_n & ~mult_pipe_full}};

  rr_arb_onehot #(
    .N  (num_req),
    .IW (idx_w)
  ) u_arb (
    .req (cand_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (launch)
  );

  assign mult_launch    = launch;
  assign mult_launch_id = {seq, gnt_idx};

  // Operand mux; stays all-zero without a grant so the multiplier inputs do not toggle.
  always_comb begin
    mult_a   = '0;
    mult_b   = '0;
    mult_rnd = '0;
    for (int i = 0; i < num_req; i++) begin
      if (gnt[i]) begin
        mult_a   = req_a[i*op_w +: op_w];
        mult_b   = req_b[i*op_w +: op_w];
        mult_rnd = req_rnd[i*3 +: 3];
      end
    end
  end

  assign dst     = mult_arrive_id[idx_w-1:0];
  assign arr_seq = mult_arrive_id[id_width-1:idx_w];

  // Steer the arrival to its owner; an id with no owner is treated as ready so it drains.
  always_comb begin
    rsp_valid    = '0;
    dst_ok       = 1'b0;
    dst_ready    = 1'b1;
    dst_cnt_zero = 1'b1;
    for (int i = 0; i < num_req; i++) begin
      if (dst == idx_w'(i)) begin
        dst_ok       = 1'b1;
        dst_ready    = rsp_ready[i];
        dst_cnt_zero = (out_cnt[i] == '0);
        rsp_valid[i] = mult_arrive;
      end
    end
  end

  assign mult_accept_n = mult_arrive & ~dst_ready;
  assign consume       = mult_arrive & dst_ready;
  assign arr_err       = consume & ((arr_seq != exp_seq) | ~dst_ok | dst_cnt_zero);
  assign rsp_z         = mult_z;
  assign rsp_status    = mult_status;
  assign busy          = |nonzero;

  assign inc_vec = {num_req{launch}} & gnt;
  assign dec_vec = {num_req{consume}} & rsp_valid;

  // Launch bookkeeping: advance the round-robin pointer past the winner and bump seq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      seq    <= '0;
    end else if (launch) begin
      rr_ptr <= (gnt_idx == idx_w'(num_req - 1)) ? '0 : gnt_idx + idx_w'(1);
      seq    <= seq + seq_w'(1);
    end
  end

  // Arrival bookkeeping: expected seq follows every consumption; errors are sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_seq <= '0;
      err     <= 1'b0;
    end else begin
      if (consume) begin
        exp_seq <= exp_seq + seq_w'(1);
      end
      if (arr_err) begin
        err <= 1'b1;
      end
    end
  end

  // Outstanding counters; a same-cycle launch and consume for one requester cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_req; i++) begin
        out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_req; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          out_cnt[i] <= out_cnt[i] + cnt_w'(1);
        end else if (dec_vec[i] && !inc_vec[i] && (out_cnt[i] != '0)) begin
          out_cnt[i] <= out_cnt[i] - cnt_w'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lp_fp_mult_sched.sv
// Directed bench for lp_fp_mult_sched (4 requesters, max_out=2).
module tb_lp_fp_mult_sched;

  localparam int N    = 4;
  localparam int OP_W = 32;
  localparam int ID_W = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*OP_W-1:0] req_a;
  logic [N*OP_W-1:0] req_b;
  logic [N*3-1:0]    req_rnd;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [OP_W-1:0]   rsp_z;
  logic [7:0]        rsp_status;
  logic              mult_launch;
  logic [ID_W-1:0]   mult_launch_id;
  logic [OP_W-1:0]   mult_a;
  logic [OP_W-1:0]   mult_b;
  logic [2:0]        mult_rnd;
  logic              mult_pipe_full;
  logic              mult_arrive;
  logic [ID_W-1:0]   mult_arrive_id;
  logic [OP_W-1:0]   mult_z;
  logic [7:0]        mult_status;
  logic              mult_accept_n;
  logic              busy;
  logic              err;

  int checks = 0;
  int fails  = 0;

  lp_fp_mult_sched #(
    .num_req   (N),
    .sig_width (23),
    .exp_width (8),
    .id_width  (ID_W),
    .max_out   (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_rnd        (req_rnd),
    .gnt            (gnt),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_z          (rsp_z),
    .rsp_status     (rsp_status),
    .mult_launch    (mult_launch),
    .mult_launch_id (mult_launch_id),
    .mult_a         (mult_a),
    .mult_b         (mult_b),
    .mult_rnd       (mult_rnd),
    .mult_pipe_full (mult_pipe_full),
    .mult_arrive    (mult_arrive),
    .mult_arrive_id (mult_arrive_id),
    .mult_z         (mult_z),
    .mult_status    (mult_status),
    .mult_accept_n  (mult_accept_n),
    .busy           (busy),
    .err            (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string      name;
    logic [3:0] r;
    logic       full;
    logic       arr;
    logic [7:0] aid;
    logic [3:0] rdy;
    logic [3:0] e_gnt;
    logic [7:0] e_id;
    logic [3:0] e_vld;
    logic       e_accn;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  // Drive one cycle of inputs just after the falling edge, then settle.
  task applyStimulus(input logic [3:0] r, input logic full, input logic arr,
                     input logic [7:0] aid, input logic [3:0] rdy);
    @(negedge clk);
    req            = r;
    mult_pipe_full = full;
    mult_arrive    = arr;
    mult_arrive_id = aid;
    rsp_ready      = rdy;
    #1;
  endtask

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task checkVec(input vec_t v);
    checkOutput({v.name, ".gnt"}, 32'(gnt), 32'(v.e_gnt));
    checkOutput({v.name, ".launch"}, 32'(mult_launch), 32'(|v.e_gnt));
    if (v.e_gnt != 4'b0000) checkOutput({v.name, ".id"}, 32'(mult_launch_id), 32'(v.e_id));
    checkOutput({v.name, ".rsp_valid"}, 32'(rsp_valid), 32'(v.e_vld));
    checkOutput({v.name, ".accept_n"}, 32'(mult_accept_n), 32'(v.e_accn));
    checkOutput({v.name, ".busy"}, 32'(busy), 32'(v.e_busy));
    checkOutput({v.name, ".err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    req            = '0;
    rsp_ready      = '1;
    mult_pipe_full = 1'b0;
    mult_arrive    = 1'b0;
    mult_arrive_id = '0;
    mult_z         = 32'h1234_5678;
    mult_status    = 8'h00;
    req_a          = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    req_b          = {32'h4100_0000, 32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000};
    req_rnd        = {3'd4, 3'd3, 3'd2, 3'd1};

    // Rotation, backpressure, steering and same-cycle launch/consume from a clean reset.
    vecs.push_back('{"rot0",   4'hF, 1'b0, 1'b0, 8'h00, 4'hF, 4'b0001, 8'h00, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"rot1",   4'hF, 1'b0, 1'b0, 8'h00, 4'hF, 4'b0010, 8'h05, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"rot2",   4'hF, 1'b0, 1'b0, 8'h00, 4'hF, 4'b0100, 8'h0A, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"rot3",   4'hF, 1'b0, 1'b0, 8'h00, 4'hF, 4'b1000, 8'h0F, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"rot4",   4'hF, 1'b0, 1'b0, 8'h00, 4'hF, 4'b0001, 8'h10, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"full0",  4'hF, 1'b1, 1'b0, 8'h00, 4'hF, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"full1",  4'hF, 1'b1, 1'b0, 8'h00, 4'hF, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"full2",  4'hF, 1'b1, 1'b0, 8'h00, 4'hF, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"resume", 4'hF, 1'b0, 1'b0, 8'h00, 4'hF, 4'b0010, 8'h15, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{"arr0",   4'h0, 1'b0, 1'b1, 8'h00, 4'hF, 4'b0000, 8'h00, 4'b0001, 1'b0, 1'b1});
    vecs.push_back('{"stall1", 4'h0, 1'b0, 1'b1, 8'h05, 4'hD, 4'b0000, 8'h00, 4'b0010, 1'b1, 1'b1});
    vecs.push_back('{"arr1",   4'h0, 1'b0, 1'b1, 8'h05, 4'hF, 4'b0000, 8'h00, 4'b0010, 1'b0, 1'b1});
    vecs.push_back('{"same2",  4'h4, 1'b0, 1'b1, 8'h0A, 4'hF, 4'b0100, 8'h1A, 4'b0100, 1'b0, 1'b1});
    vecs.push_back('{"arr3",   4'h0, 1'b0, 1'b1, 8'h0F, 4'hF, 4'b0000, 8'h00, 4'b1000, 1'b0, 1'b1});
    vecs.push_back('{"arr0b",  4'h0, 1'b0, 1'b1, 8'h10, 4'hF, 4'b0000, 8'h00, 4'b0001, 1'b0, 1'b1});
    vecs.push_back('{"arr1b",  4'h0, 1'b0, 1'b1, 8'h15, 4'hF, 4'b0000, 8'h00, 4'b0010, 1'b0, 1'b1});
    vecs.push_back('{"arr2b",  4'h0, 1'b0, 1'b1, 8'h1A, 4'hF, 4'b0000, 8'h00, 4'b0100, 1'b0, 1'b1});
    vecs.push_back('{"idle",   4'h0, 1'b0, 1'b0, 8'h00, 4'hF, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0});

    // Reset state.
    #12;
    checkOutput("reset.gnt", 32'(gnt), 32'd0);
    checkOutput("reset.launch", 32'(mult_launch), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].r, vecs[k].full, vecs[k].arr, vecs[k].aid, vecs[k].rdy);
      checkVec(vecs[k]);
    end

    // Single requester from a fresh reset: 2.0 * 3.0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a[63:32]  = 32'h4000_0000;
    req_b[63:32]  = 32'h4040_0000;
    req_rnd[5:3]  = 3'd1;
    applyStimulus(4'b0010, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("single.gnt", 32'(gnt), 32'h2);
    checkOutput("single.id", 32'(mult_launch_id), 32'h01);
    checkOutput("single.a", mult_a, 32'h4000_0000);
    checkOutput("single.b", mult_b, 32'h4040_0000);
    checkOutput("single.rnd", 32'(mult_rnd), 32'd1);
    mult_z      = 32'h40C0_0000;
    mult_status = 8'h20;
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h01, 4'hF);
    checkOutput("single.iso_a", mult_a, 32'h0);
    checkOutput("single.rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("single.rsp_z", rsp_z, 32'h40C0_0000);
    checkOutput("single.rsp_status", 32'(rsp_status), 32'h20);
    checkOutput("single.accept_n", 32'(mult_accept_n), 32'd0);
    checkOutput("single.busy_held", 32'(busy), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("single.busy_clr", 32'(busy), 32'd0);

    // Outstanding limit: requester 0 alone, not ready for its results.
    applyStimulus(4'b0001, 1'b0, 1'b0, 8'h00, 4'hE);
    checkOutput("lim.l1_id", 32'(mult_launch_id), 32'h04);
    applyStimulus(4'b0001, 1'b0, 1'b0, 8'h00, 4'hE);
    checkOutput("lim.l2_id", 32'(mult_launch_id), 32'h08);
    applyStimulus(4'b0001, 1'b0, 1'b1, 8'h04, 4'hE);
    checkOutput("lim.blocked_gnt", 32'(gnt), 32'd0);
    checkOutput("lim.accept_n", 32'(mult_accept_n), 32'd1);
    applyStimulus(4'b0001, 1'b0, 1'b1, 8'h04, 4'hE);
    checkOutput("lim.hold_gnt", 32'(gnt), 32'd0);
    checkOutput("lim.hold_accept_n", 32'(mult_accept_n), 32'd1);
    applyStimulus(4'b0001, 1'b0, 1'b1, 8'h04, 4'hF);
    checkOutput("lim.consume_accept_n", 32'(mult_accept_n), 32'd0);
    checkOutput("lim.consume_gnt", 32'(gnt), 32'd0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("lim.regrant", 32'(gnt), 32'h1);
    checkOutput("lim.regrant_id", 32'(mult_launch_id), 32'h0C);
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h08, 4'hF);
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h0C, 4'hF);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("lim.busy_clr", 32'(busy), 32'd0);
    checkOutput("lim.err", 32'(err), 32'd0);

    // Wrong sequence field on an arrival sets the sticky error.
    applyStimulus(4'b1000, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("seqerr.launch_id", 32'(mult_launch_id), 32'h13);
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h1B, 4'hF);
    checkOutput("seqerr.rsp_valid", 32'(rsp_valid), 32'h8);
    checkOutput("seqerr.err_before", 32'(err), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("seqerr.err_set", 32'(err), 32'd1);
    checkOutput("seqerr.busy", 32'(busy), 32'd0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("seqerr.gnt_a", 32'(gnt), 32'h1);
    checkOutput("seqerr.id_a", 32'(mult_launch_id), 32'h14);
    applyStimulus(4'b1111, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("seqerr.gnt_b", 32'(gnt), 32'h2);
    checkOutput("seqerr.err_sticky", 32'(err), 32'd1);

    // Asynchronous reset in the middle of the stream.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.gnt", 32'(gnt), 32'd0);
    checkOutput("midrst.launch", 32'(mult_launch), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkOutput("midrst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst.restart_gnt", 32'(gnt), 32'h1);
    checkOutput("midrst.restart_id", 32'(mult_launch_id), 32'h00);

    // Arrival for a requester with nothing outstanding: error, counter holds at zero.
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("under.busy_pre", 32'(busy), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h02, 4'hF);
    checkOutput("under.rsp_valid", 32'(rsp_valid), 32'h4);
    checkOutput("under.err_before", 32'(err), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("under.err_set", 32'(err), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 8'h00, 4'hF);
    applyStimulus(4'b0000, 1'b0, 1'b0, 8'h00, 4'hF);
    checkOutput("under.busy_clr", 32'(busy), 32'd0);
    checkOutput("under.err_sticky", 32'(err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
